// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction lamp safety monitor.
package traffic_pkg;

  // Direction indices into the 4-bit lamp vectors.
  localparam int unsigned DIR_E = 0;
  localparam int unsigned DIR_N = 1;
  localparam int unsigned DIR_W = 2;
  localparam int unsigned DIR_S = 3;

  // Decoded state of one signal head.
  typedef enum logic [1:0] {
    DirRed,
    DirYellow,
    DirGreen,
    DirInvalid
  } dir_state_e;

  // Latched fault codes.
  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_LAMP     = 3'd2;
  localparam logic [2:0] FC_SKIP_Y   = 3'd3;
  localparam logic [2:0] FC_SHORT_Y  = 3'd4;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    StMonitor,
    StFault,
    StClear
  } mon_state_e;

  // Exactly one lit lamp gives a valid state; anything else is INVALID.
  function automatic dir_state_e decode_dir(logic g, logic y, logic r);
    dir_state_e st;
    unique case ({g, y, r})
      3'b100:  st = DirGreen;
      3'b010:  st = DirYellow;
      3'b001:  st = DirRed;
      default: st = DirInvalid;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp drive bundle from the controller plus the monitor's fault outputs.
interface traffic_conflict_monitor_if;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic       mode_select;
  logic       fault_clear;
  logic       fault;
  logic [2:0] fault_code;
  logic       force_red;
  logic       flash;

  // Upstream side: drives lamps and operator clear, observes the monitor.
  modport master (
    output green, yellow, red, mode_select, fault_clear,
    input  fault, fault_code, force_red, flash
  );

  // Monitor side.
  modport slave (
    input  green, yellow, red, mode_select, fault_clear,
    output fault, fault_code, force_red, flash
  );
endinterface

// File: rtl/lamp_dir_checker.sv
// Per-direction lamp checker: state decode, INVALID persistence counter,
// yellow-duration counter and RED-entry transition checks.
module lamp_dir_checker
  import traffic_pkg::*;
#(
  parameter int unsigned LAMP_TOL       = 4,
  parameter int unsigned YELLOW_MIN_CYC = 80_000_000
) (
  input  logic clk,
  input  logic p_reset,
  input  logic en,        // monitoring active: advance counters and previous sample
  input  logic clr,       // one-cycle clear after an accepted fault clear
  input  logic g,
  input  logic y,
  input  logic r,
  output logic open,
  output logic lamp_err,
  output logic skip_err,
  output logic short_err
);

  localparam int unsigned LW = $clog2(LAMP_TOL + 1);
  localparam int unsigned YW = $clog2(YELLOW_MIN_CYC + 1);
  localparam logic [LW-1:0] LampMax  = LW'(LAMP_TOL);
  localparam logic [LW-1:0] LampLast = LW'(LAMP_TOL - 1);
  localparam logic [YW-1:0] YelMax   = YW'(YELLOW_MIN_CYC);

  dir_state_e    cur;
  dir_state_e    prev_q, prev_d;
  logic [LW-1:0] lamp_q, lamp_d;
  logic [YW-1:0] yel_q, yel_d;

  // Next-state for the previous sample and both counters.
  always_comb begin
    cur    = decode_dir(g, y, r);
    prev_d = prev_q;
    lamp_d = lamp_q;
    yel_d  = yel_q;
    if (clr) begin
      prev_d = DirRed;
      lamp_d = '0;
      yel_d  = '0;
    end else if (en) begin
      prev_d = cur;
      if (cur == DirInvalid) begin
        if (lamp_q != LampMax) lamp_d = lamp_q + 1'b1;
      end else begin
        lamp_d = '0;
      end
      // Entry cycle counts as the first yellow cycle.
      if (cur == DirYellow) begin
        if (prev_q != DirYellow) yel_d = YW'(1);
        else if (yel_q != YelMax) yel_d = yel_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!p_reset) begin
      prev_q <= DirRed;
      lamp_q <= '0;
      yel_q  <= '0;
    end else begin
      prev_q <= prev_d;
      lamp_q <= lamp_d;
      yel_q  <= yel_d;
    end
  end

  // Error flags; lamp_err fires on the cycle the counter would reach LAMP_TOL.
  always_comb begin
    open      = (cur == DirGreen) || (cur == DirYellow);
    lamp_err  = (cur == DirInvalid) && (lamp_q >= LampLast);
    skip_err  = (prev_q == DirGreen) && (cur == DirRed);
    short_err = (prev_q == DirYellow) && (cur == DirRed) && (yel_q < YelMax);
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Junction lamp safety monitor: samples the lamp drives, checks for conflicts,
// invalid heads and bad yellow phases, and latches the first fault.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 40_000_000,
  parameter int unsigned YELLOW_MIN_S = 2,
  parameter int unsigned LAMP_TOL     = 4
) (
  input logic                       clk,
  input logic                       p_reset,
  traffic_conflict_monitor_if.slave bus
);

  localparam int unsigned YELLOW_MIN_CYC = YELLOW_MIN_S * CLK_HZ;
  localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TickLast = TW'(CLK_HZ - 1);

  logic [3:0] s_green, s_yellow, s_red;
  logic       s_mode;
  logic [3:0] open, lamp_err, skip_err, short_err;
  logic       conflict, all_red, tick, en, clr;
  logic [2:0] raised;

  mon_state_e    state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          flash_q, flash_d;

  // Sample stage: every check works from registered lamp inputs.
  always_ff @(posedge clk) begin
    if (!p_reset) begin
      s_green  <= 4'h0;
      s_yellow <= 4'h0;
      s_red    <= 4'hf;
      s_mode   <= 1'b0;
    end else begin
      s_green  <= bus.green;
      s_yellow <= bus.yellow;
      s_red    <= bus.red;
      s_mode   <= bus.mode_select;
    end
  end

  assign en  = (state_q == StMonitor);
  assign clr = (state_q == StClear);

  for (genvar i = 0; i < 4; i++) begin : g_dir
    lamp_dir_checker #(
      .LAMP_TOL       (LAMP_TOL),
      .YELLOW_MIN_CYC (YELLOW_MIN_CYC)
    ) u_dir (
      .clk       (clk),
      .p_reset   (p_reset),
      .en        (en),
      .clr       (clr),
      .g         (s_green[i]),
      .y         (s_yellow[i]),
      .r         (s_red[i]),
      .open      (open[i]),
      .lamp_err  (lamp_err[i]),
      .skip_err  (skip_err[i]),
      .short_err (short_err[i])
    );
  end

  // Conflict detection and fault priority encoding.
  always_comb begin
    if (s_mode) begin
      // Only E+W or N+S may be open together.
      conflict = (open[DIR_E] | open[DIR_W]) & (open[DIR_N] | open[DIR_S]);
    end else begin
      conflict = (open & (open - 4'd1)) != 4'd0;
    end
    all_red = (s_red == 4'hf) && (s_green == 4'h0) && (s_yellow == 4'h0);
    raised  = FC_NONE;
    if (conflict)          raised = FC_CONFLICT;
    else if (|lamp_err)    raised = FC_LAMP;
    else if (|skip_err)    raised = FC_SKIP_Y;
    else if (|short_err)   raised = FC_SHORT_Y;
  end

  assign tick = (tick_q == TickLast);

  // FSM next-state, fault latch, tick counter and flash toggle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tick_d  = tick ? '0 : tick_q + 1'b1;
    flash_d = flash_q;
    unique case (state_q)
      StMonitor: begin
        if (raised != FC_NONE) begin
          state_d = StFault;
          code_d  = raised;
          tick_d  = '0;
          flash_d = 1'b1;
        end
      end
      StFault: begin
        if (tick) flash_d = ~flash_q;
        if (bus.fault_clear && all_red) state_d = StClear;
      end
      StClear: begin
        state_d = StMonitor;
        code_d  = FC_NONE;
        flash_d = 1'b0;
      end
      default: state_d = StMonitor;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (!p_reset) begin
      state_q <= StMonitor;
      code_q  <= FC_NONE;
      tick_q  <= '0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tick_q  <= tick_d;
      flash_q <= flash_d;
    end
  end

  assign bus.fault      = (state_q != StMonitor);
  assign bus.force_red  = (state_q != StMonitor);
  assign bus.fault_code = code_q;
  assign bus.flash      = flash_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor (CLK_HZ=8, yellow min 16 cycles).
module tb_traffic_conflict_monitor;

  localparam logic [11:0] ALL_RED = 12'h00f;  // {green, yellow, red}

  logic clk = 1'b0;
  logic p_reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor #(
    .CLK_HZ       (8),
    .YELLOW_MIN_S (2),
    .LAMP_TOL     (4)
  ) dut (
    .clk     (clk),
    .p_reset (p_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mode;
    logic [11:0] lamp_a;
    int          n_a;
    logic [11:0] lamp_b;
    int          n_b;
    logic        exp_fault;
    logic [2:0]  exp_code;
  } vec_t;

  vec_t vecs[14];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [11:0] l);
    bus.green  = l[11:8];
    bus.yellow = l[7:4];
    bus.red    = l[3:0];
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    p_reset = 1'b0;
    apply(ALL_RED);
    bus.mode_select = 1'b0;
    bus.fault_clear = 1'b0;
    step(2);
    p_reset = 1'b1;
  endtask

  function automatic vec_t mk(string nm, logic m, logic [11:0] a, int na, logic [11:0] b,
                              int nb, logic ef, logic [2:0] ec);
    vec_t v;
    v.name = nm; v.mode = m; v.lamp_a = a; v.n_a = na; v.lamp_b = b; v.n_b = nb;
    v.exp_fault = ef; v.exp_code = ec;
    return v;
  endfunction

  initial begin
    logic [3:0] one;

    // lamp words are {green[3:0], yellow[3:0], red[3:0]}; bit 0=E 1=N 2=W 3=S
    vecs[0]  = mk("m0_e_only",       1'b0, 12'h10e, 6,  12'h10e, 3, 1'b0, 3'd0);
    vecs[1]  = mk("m0_e_n_green",    1'b0, 12'h30c, 4,  ALL_RED, 2, 1'b1, 3'd1);
    vecs[2]  = mk("m0_e_w_green",    1'b0, 12'h50a, 4,  ALL_RED, 2, 1'b1, 3'd1);
    vecs[3]  = mk("m1_e_w_green",    1'b1, 12'h50a, 10, 12'h50a, 3, 1'b0, 3'd0);
    vecs[4]  = mk("m1_e_w_n_green",  1'b1, 12'h708, 4,  ALL_RED, 2, 1'b1, 3'd1);
    vecs[5]  = mk("w_dark_3",        1'b0, 12'h00b, 3,  ALL_RED, 4, 1'b0, 3'd0);
    vecs[6]  = mk("w_dark_4",        1'b0, 12'h00b, 4,  ALL_RED, 3, 1'b1, 3'd2);
    vecs[7]  = mk("s_gr_4",          1'b0, 12'h80f, 4,  ALL_RED, 3, 1'b1, 3'd2);
    vecs[8]  = mk("n_skip_yellow",   1'b0, 12'h20d, 5,  ALL_RED, 3, 1'b1, 3'd3);
    vecs[9]  = mk("n_yellow_15",     1'b0, 12'h02d, 15, ALL_RED, 3, 1'b1, 3'd4);
    vecs[10] = mk("n_yellow_16",     1'b0, 12'h02d, 16, ALL_RED, 3, 1'b0, 3'd0);
    vecs[11] = mk("prio_conf_skip",  1'b0, 12'h20d, 3,  12'h50a, 3, 1'b1, 3'd1);
    vecs[12] = mk("prio_lamp_skip",  1'b0, 12'h209, 3,  12'h00b, 3, 1'b1, 3'd2);
    vecs[13] = mk("prio_skip_short", 1'b1, 12'h14a, 3,  ALL_RED, 3, 1'b1, 3'd3);

    bus.fault_clear = 1'b0;
    bus.mode_select = 1'b0;
    apply(ALL_RED);

    // Reset values
    do_reset();
    check("rst_fault", bus.fault, 0);
    check("rst_code", bus.fault_code, 0);
    check("rst_force_red", bus.force_red, 0);
    check("rst_flash", bus.flash, 0);

    // Table-driven scenarios, each from reset
    foreach (vecs[i]) begin
      do_reset();
      bus.mode_select = vecs[i].mode;
      apply(vecs[i].lamp_a);
      step(vecs[i].n_a);
      apply(vecs[i].lamp_b);
      step(vecs[i].n_b);
      check({vecs[i].name, "_fault"}, bus.fault, vecs[i].exp_fault);
      check({vecs[i].name, "_code"}, bus.fault_code, vecs[i].exp_code);
    end

    // Legal mode-0 rotation E, N, W, S for 200 cycles
    do_reset();
    for (int d = 0; d < 4; d++) begin
      one = 4'(1 << d);
      apply({one, 4'h0, ~one});
      step(10);
      apply({4'h0, one, ~one});
      step(16);
      apply(ALL_RED);
      step(2);
      check($sformatf("legal_cycle_dir%0d", d), bus.fault, 0);
    end
    step(88);
    check("legal_cycle_200", bus.fault, 0);

    // Conflict latency: captured after one edge, fault after the second
    do_reset();
    step(3);
    apply(12'h30c);
    step(1);
    check("conf_lat_early", bus.fault, 0);
    step(1);
    check("conf_lat_fault", bus.fault, 1);
    check("conf_lat_code", bus.fault_code, 1);
    check("conf_lat_force_red", bus.force_red, 1);
    check("conf_lat_flash", bus.flash, 1);

    // Flash toggles every 8 cycles from FAULT entry
    step(7);
    check("flash_e7", bus.flash, 1);
    step(1);
    check("flash_e8", bus.flash, 0);
    step(7);
    check("flash_e15", bus.flash, 0);
    step(1);
    check("flash_e16", bus.flash, 1);

    // Clear refused while E is green
    bus.fault_clear = 1'b1;
    apply(12'h10e);
    step(4);
    check("clear_refused", bus.fault, 1);

    // Clear accepted with all red: in s after one edge, CLEAR after two, out after three
    apply(ALL_RED);
    step(2);
    check("clear_in_clear_fault", bus.fault, 1);
    check("clear_in_clear_force", bus.force_red, 1);
    step(1);
    check("clear_done_fault", bus.fault, 0);
    check("clear_done_force", bus.force_red, 0);
    check("clear_done_flash", bus.flash, 0);
    check("clear_done_code", bus.fault_code, 0);
    bus.fault_clear = 1'b0;
    step(5);
    check("post_clear_quiet", bus.fault, 0);

    // Monitoring resumes after clear: N skips yellow
    apply(12'h20d);
    step(3);
    apply(ALL_RED);
    step(2);
    check("post_clear_skip_code", bus.fault_code, 3);

    // Reset in the middle of FAULT
    p_reset = 1'b0;
    step(1);
    check("midrst_fault", bus.fault, 0);
    check("midrst_code", bus.fault_code, 0);
    check("midrst_force", bus.force_red, 0);
    check("midrst_flash", bus.flash, 0);
    p_reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
